// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Latency: accept at edge k -> out_valid after edge k+WIDTH; one word per WIDTH+2 cycles max.
// Backpressure: holds result in DONE until out_ready; in_ready only while IDLE.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake, bin sampled on accept
//   bin [WIDTH-1:0]     unsigned binary operand
//   out_valid/out_ready output handshake
//   bcd [4*DIGITS-1:0]  packed BCD, digit 0 (units) in bcd[3:0]
module bin_to_bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      bin,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int ACC_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(WIDTH);

    function automatic longint pow10(input int n);
        longint p;
        p = 1;
        for (int i = 0; i < n; i++) begin
            p = p * 10;
        end
        return p;
    endfunction

    // Reject configurations where the accumulator could overflow.
    generate
        if (WIDTH < 4 || WIDTH > 16) begin : g_bad_width
            $error("bin_to_bcd_seq: WIDTH must be in 4..16");
        end
        if (pow10(DIGITS) <= ((longint'(1) << WIDTH) - 1)) begin : g_bad_digits
            $error("bin_to_bcd_seq: DIGITS too small for WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   bin_sr;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_adj;
    logic [CNT_W-1:0]   cnt;
    logic               last_iter;
    logic               accept;

    assign last_iter = (cnt == CNT_W'(WIDTH - 1));
    assign accept    = in_valid && in_ready;
    assign bcd       = acc;

    // Per-digit add-3 before the shift: a digit >= 5 would reach >= 10 when
    // doubled, so pre-adding 3 makes the shift carry into the next digit.
    always_comb begin
        acc_adj = acc;
        for (int d = 0; d < DIGITS; d++) begin
            if (acc[4*d +: 4] >= 4'd5) begin
                acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Handshake outputs are pure state decodes: no input-to-output path.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (last_iter) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_sr <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        bin_sr <= bin;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                S_SHIFT: begin
                    acc    <= {acc_adj[ACC_W-2:0], bin_sr[WIDTH-1]};
                    bin_sr <= {bin_sr[WIDTH-2:0], 1'b0};
                    if (!last_iter) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    // DONE: acc held as the result, nothing else moves.
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
module tb_bin_to_bcd_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    logic        iv8, ir8, ov8, or8;
    logic [7:0]  bin8;
    logic [11:0] bcd8;

    logic        iv4, ir4, ov4, or4;
    logic [3:0]  bin4;
    logic [7:0]  bcd4;

    int errors = 0;
    int checks = 0;
    int sel    = 0;

    logic        cur_ir, cur_ov;
    logic [31:0] cur_bcd;

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(3)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv8),
        .in_ready  (ir8),
        .bin       (bin8),
        .out_valid (ov8),
        .out_ready (or8),
        .bcd       (bcd8)
    );

    bin_to_bcd_seq #(.WIDTH(4), .DIGITS(2)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (iv4),
        .in_ready  (ir4),
        .bin       (bin4),
        .out_valid (ov4),
        .out_ready (or4),
        .bcd       (bcd4)
    );

    always_comb begin
        cur_ir  = (sel != 0) ? ir4 : ir8;
        cur_ov  = (sel != 0) ? ov4 : ov8;
        cur_bcd = (sel != 0) ? {24'b0, bcd4} : {20'b0, bcd8};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: decimal digits by plain division.
    function automatic logic [31:0] ref_bcd(input int v, input int nd);
        logic [31:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic nibbles_ok(input logic [31:0] x, input int nd);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < nd; i++) begin
            if (x[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    task automatic drive_in(input logic v, input logic [15:0] b);
        if (sel != 0) begin
            iv4  = v;
            bin4 = b[3:0];
        end else begin
            iv8  = v;
            bin8 = b[7:0];
        end
    endtask

    task automatic drive_or(input logic r);
        if (sel != 0) or4 = r;
        else          or8 = r;
    endtask

    // Called at a negedge; returns at the negedge after the output handshake.
    task automatic conv(input int v, input int stall);
        int          w;
        int          nd;
        int          lat;
        int          t;
        logic [31:0] exp;
        w  = (sel != 0) ? 4 : 8;
        nd = (sel != 0) ? 2 : 3;
        drive_or(stall == 0);
        t = 0;
        while (!cur_ir && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("wait_ready", 32'(cur_ir), 32'd1);
        drive_in(1'b1, 16'(v));
        @(posedge clk);
        #1 drive_in(1'b0, 16'($urandom));
        lat = 0;
        @(negedge clk);
        while (!cur_ov && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        exp = ref_bcd(v, nd);
        check("latency", 32'(lat), 32'(w));
        check("bcd", cur_bcd, exp);
        check("nibbles", 32'(nibbles_ok(cur_bcd, nd)), 32'd1);
        if (stall > 0) begin
            for (int i = 0; i < stall; i++) begin
                drive_in(1'($urandom % 2), 16'($urandom));
                @(negedge clk);
                check("stall_bcd", cur_bcd, exp);
                check("stall_ov", 32'(cur_ov), 32'd1);
                check("stall_ir", 32'(cur_ir), 32'd0);
            end
            drive_in(1'b0, 16'd0);
            drive_or(1'b1);
        end
        @(negedge clk);
        check("hs_ov", 32'(cur_ov), 32'd0);
        check("hs_ir", 32'(cur_ir), 32'd1);
    endtask

    initial begin
        int          acc_c [2];
        logic [11:0] outs [2];
        int          n_acc;
        int          n_out;
        logic        seen;

        rst_n = 1'b0;
        iv8 = 1'b0; bin8 = '0; or8 = 1'b1;
        iv4 = 1'b0; bin4 = '0; or4 = 1'b1;
        #1;
        check("rst_ir8", 32'(ir8), 32'd1);
        check("rst_ov8", 32'(ov8), 32'd0);
        check("rst_bcd8", {20'b0, bcd8}, 32'd0);
        check("rst_ir4", 32'(ir4), 32'd1);
        check("rst_ov4", 32'(ov4), 32'd0);
        repeat (3) @(negedge clk);
        check("rst_hold_ir", 32'(ir8), 32'd1);
        check("rst_hold_ov", 32'(ov8), 32'd0);
        rst_n = 1'b1;

        // Directed values, first one right at the first edge after release.
        sel = 0;
        conv(0, 0);
        conv(255, 0);
        conv(99, 0);
        conv(100, 0);
        conv(9, 0);

        for (int v = 0; v < 256; v++) conv(v, 0);

        // Backpressure with bin/in_valid wiggling during the stall.
        conv(173, 5);

        // Back-to-back with in_valid and out_ready held high.
        n_acc = 0;
        n_out = 0;
        or8   = 1'b1;
        bin8  = 8'd42;
        iv8   = 1'b1;
        for (int c = 0; c < 60 && n_out < 2; c++) begin
            if (n_acc >= 1) bin8 = 8'd201;
            if (ov8) begin
                outs[n_out] = bcd8;
                n_out++;
                if (n_out == 2) iv8 = 1'b0;
            end
            if (ir8 && iv8 && n_acc < 2) begin
                acc_c[n_acc] = c;
                n_acc++;
            end
            @(negedge clk);
        end
        iv8 = 1'b0;
        check("b2b_accepts", 32'(n_acc), 32'd2);
        check("b2b_outputs", 32'(n_out), 32'd2);
        if (n_acc == 2) check("b2b_spacing", 32'(acc_c[1] - acc_c[0]), 32'd10);
        if (n_out == 2) begin
            check("b2b_out0", {20'b0, outs[0]}, ref_bcd(42, 3));
            check("b2b_out1", {20'b0, outs[1]}, ref_bcd(201, 3));
        end

        // Asynchronous reset in the middle of a conversion.
        iv8  = 1'b1;
        bin8 = 8'd250;
        @(posedge clk);
        #1 iv8 = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_ir", 32'(ir8), 32'd1);
        check("arst_ov", 32'(ov8), 32'd0);
        check("arst_bcd", {20'b0, bcd8}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen = seen | ov8;
        end
        check("arst_no_ov", 32'(seen), 32'd0);

        // Random values with random stalls.
        repeat (30) conv(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));

        // Narrow configuration.
        sel = 1;
        conv(9, 0);
        conv(15, 0);
        repeat (10) conv(int'($urandom_range(0, 15)), int'($urandom_range(0, 2)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) that produces packed BCD digits for the downstream combinational BCD-to-excess-3 converter. It accepts one unsigned binary word per transaction over a valid/ready handshake. It iterates WIDTH cycles, then holds the packed BCD result until the consumer accepts it. Each 4-bit digit of the output feeds one bcd_to_xs3 instance directly.

## Interface
- WIDTH, 8: binary input width; legal range 4..16.
- DIGITS, 3: number of BCD output digits. Must satisfy 10^DIGITS > 2^WIDTH-1 (8→3, 4→2, 16→5). Elaboration fails otherwise.
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset; one clock, reset is asynchronous and active-low.
- in_valid  input  1  bin holds a word to convert.
- in_ready  output  1  block can accept a word; high only in IDLE.
- bin  input  WIDTH  unsigned binary operand; sampled only on accept.
- out_valid  output  1  bcd holds a completed result.
- out_ready  input  1  consumer accepts the result.
- bcd  output  4*DIGITS  packed BCD; digit i occupies bcd[4i+3:4i], with digit 0 as units; every digit is 0..9.

## Operation
- States are IDLE, SHIFT and DONE, held in registers. The datapath has bin_sr (WIDTH), acc (4*DIGITS) and cnt (counts 0..WIDTH-1).
- IDLE
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: bin_sr←bin, acc←0, cnt←0, go to SHIFT.
- SHIFT, one iteration per cycle:
  - For every digit d of acc: if d≥5 then d←d+3 (4-bit add, no carry between digits).
  - Then acc←{acc_adj[4*DIGITS-2:0], bin_sr[WIDTH-1]} and bin_sr←bin_sr<<1.
  - After the iteration with cnt==WIDTH-1, go to DONE. Otherwise cnt←cnt+1.
  - in_valid is ignored and in_ready=0.
- DONE
  - out_valid=1 and bcd=acc, stable until the handshake.
  - On out_valid&&out_ready, go to IDLE. acc is retained but out_valid drops.
- bcd is driven from acc at all times. Its value is meaningful only while out_valid=1.
- The add-3 correction never produces a digit above 9 after shifting. The DIGITS constraint guarantees no bit is shifted out of acc's MSB.
- bin changing after accept has no effect on the result.

## Timing
- Reset (asynchronous assert, synchronous-style release on the next edge):
  - state=IDLE, acc=0, bin_sr=0, cnt=0.
  - Outputs: in_ready=1, out_valid=0, bcd=0.
  - These values take effect immediately on rst_n falling, without waiting for a clock.
- Latency: if the accept occurs at rising edge k, out_valid rises after edge k+WIDTH (WIDTH shift edges k+1..k+WIDTH).
- With out_ready held high, the handshake completes at edge k+WIDTH+1 and in_ready is high after it. Maximum throughput is one word per WIDTH+2 cycles.
- in_ready and out_valid are pure decodes of the state register, so there is no combinational path from any input to any output.
- out_ready low in DONE stalls indefinitely with bcd unchanged.
- A reset asserted mid-SHIFT or in DONE aborts the conversion. No out_valid pulse follows.
- After reset release, the first accept is possible at the first edge.

## Test plan
- Reset values and basic conversion:
  - Stimulus: hold rst_n=0 for 3 cycles, then release. Present bin=8'd0 with in_valid=1 and out_ready=1.
  - Required: in_ready=1 and out_valid=0 during reset. out_valid goes high exactly 8 cycles after the accept edge, with bcd=12'h000.
- Full-range values (WIDTH=8):
  - Stimulus: convert bin=255, 99, 100 and 9.
  - Required: bcd=12'h255, 12'h099, 12'h100, 12'h009 respectively.
  - Sweep all 0..255 against a reference model; every nibble must be ≤9.
- Backpressure:
  - Stimulus: convert bin=173 with out_ready=0 for 5 cycles after out_valid rises, while changing bin and pulsing in_valid.
  - Required: bcd stays 12'h173, out_valid stays 1 and in_ready stays 0. Both drop/rise on the out_ready handshake edge.
- Back-to-back:
  - Stimulus: hold in_valid=1 and out_ready=1 with bin=42 then 201.
  - Required: accepts are spaced exactly 10 cycles apart. Outputs are 12'h042 then 12'h201.
- Reset mid-operation:
  - Stimulus: accept bin=250, then assert rst_n=0 asynchronously (between edges) 4 cycles later.
  - Required: in_ready=1, out_valid=0 and bcd=0 immediately on assertion, with no later out_valid for 250.
- Alternate configuration:
  - Stimulus: use WIDTH=4, DIGITS=2 and convert 9 then 15.
  - Required: bcd=8'h09 and 8'h15, each with a latency of 4 cycles.
